// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - command-sequenced corelet: L0 FIFO, weight-stationary MAC, OFIFO and per-column SFP accumulators
module corelet_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int len_bw  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [len_bw-1:0]        cmd_len,
    input  logic                     cmd_acc,
    input  logic                     cmd_relu,
    input  logic [bw*row-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [psum_bw*col-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    localparam int l0_depth = (col < 2) ? 2 : col;
    localparam int l0_aw    = $clog2(l0_depth);
    localparam int of_depth = 4;
    localparam int of_aw    = 2;
    localparam int cnt_bw   = ((len_bw > 12) ? len_bw : 12) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LDW_FILL, S_LDW_ISSUE, S_EXEC, S_DRAIN, S_RD_ACC, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [len_bw-1:0]      len_q;
    logic                   acc_q, relu_q;
    logic [cnt_bw-1:0]      cnt_in, cnt_iss, cnt_pop;

    logic [bw*row-1:0]      l0_mem [l0_depth];
    logic [l0_aw-1:0]       l0_wp, l0_rp;
    logic [l0_aw:0]         l0_cnt;
    logic [psum_bw*col-1:0] of_mem [of_depth];
    logic [of_aw-1:0]       of_wp, of_rp;
    logic [of_aw:0]         of_cnt;

    logic [bw*row-1:0]      w_vec [col];
    logic [psum_bw-1:0]     acc [col];

    logic [bw*row-1:0]      l0_head;
    logic [psum_bw*col-1:0] of_head, mac_vec, rd_vec;
    logic                   l0_full, l0_empty, of_full, of_empty;
    logic                   l0_push, l0_pop, of_push, of_pop, cmd_accept;
    logic [psum_bw-1:0]     sum, a_ext, w_ext;

    assign l0_head    = l0_mem[l0_rp];
    assign of_head    = of_mem[of_rp];
    assign l0_full    = (l0_cnt == (l0_aw+1)'(l0_depth));
    assign l0_empty   = (l0_cnt == '0);
    assign of_full    = (of_cnt == (of_aw+1)'(of_depth));
    assign of_empty   = (of_cnt == '0);
    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign cmd_accept = cmd_valid && (state == S_IDLE);
    assign l0_push    = in_valid && in_ready;
    assign of_push    = l0_pop && (state == S_EXEC);

    always_comb begin
        in_ready = 1'b0;
        l0_pop   = 1'b0;
        of_pop   = 1'b0;
        case (state)
            S_LDW_FILL:  in_ready = !l0_full && (cnt_in < cnt_bw'(col));
            S_LDW_ISSUE: l0_pop   = (cnt_iss < cnt_bw'(col));
            S_EXEC: begin
                in_ready = !l0_full && (cnt_in < cnt_bw'(len_q));
                l0_pop   = !l0_empty && !of_full && (cnt_iss < cnt_bw'(len_q));
            end
            default: ;
        endcase
        if (state == S_EXEC || state == S_DRAIN)
            of_pop = !of_empty && (acc_q || out_ready);
    end

    // Activations are unsigned lanes, weights are signed; products wrap at psum_bw.
    always_comb begin
        mac_vec = '0;
        sum     = '0;
        a_ext   = '0;
        w_ext   = '0;
        for (int c = 0; c < col; c++) begin
            sum = '0;
            for (int r = 0; r < row; r++) begin
                a_ext = psum_bw'(l0_head[bw*r +: bw]);
                w_ext = {{(psum_bw-bw){w_vec[c][bw*r+bw-1]}}, w_vec[c][bw*r +: bw]};
                sum   = sum + a_ext * w_ext;
            end
            mac_vec[psum_bw*c +: psum_bw] = sum;
        end
    end

    always_comb begin
        rd_vec = '0;
        for (int c = 0; c < col; c++)
            rd_vec[psum_bw*c +: psum_bw] = (relu_q && acc[c][psum_bw-1]) ? '0 : acc[c];
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if ((state == S_EXEC || state == S_DRAIN) && !acc_q && !of_empty) begin
            out_valid = 1'b1;
            out_data  = of_head;
        end else if (state == S_RD_ACC) begin
            out_valid = 1'b1;
            out_data  = rd_vec;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (cmd_valid) begin
                case (cmd_op)
                    2'b01:   state_nx = S_LDW_FILL;
                    2'b10:   state_nx = (cmd_len == '0) ? S_DONE : S_EXEC;
                    2'b11:   state_nx = S_RD_ACC;
                    default: state_nx = S_DONE;
                endcase
            end
            S_LDW_FILL:  if (cnt_in == cnt_bw'(col)) state_nx = S_LDW_ISSUE;
            // col load cycles followed by row+col idle cycles for propagation
            S_LDW_ISSUE: if (cnt_iss == cnt_bw'(2*col + row - 1)) state_nx = S_DONE;
            S_EXEC:      if (cnt_iss == cnt_bw'(len_q)) state_nx = S_DRAIN;
            S_DRAIN:     if (cnt_pop == cnt_bw'(len_q)) state_nx = S_DONE;
            S_RD_ACC:    if (out_ready) state_nx = S_DONE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (l0_push) l0_mem[l0_wp] <= in_data;
        if (of_push) of_mem[of_wp] <= mac_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            len_q   <= '0;
            acc_q   <= 1'b0;
            relu_q  <= 1'b0;
            cnt_in  <= '0;
            cnt_iss <= '0;
            cnt_pop <= '0;
            l0_wp   <= '0;
            l0_rp   <= '0;
            l0_cnt  <= '0;
            of_wp   <= '0;
            of_rp   <= '0;
            of_cnt  <= '0;
            for (int c = 0; c < col; c++) begin
                w_vec[c] <= '0;
                acc[c]   <= '0;
            end
        end else begin
            state <= state_nx;
            if (cmd_accept) begin
                len_q   <= cmd_len;
                acc_q   <= cmd_acc;
                relu_q  <= cmd_relu;
                cnt_in  <= '0;
                cnt_iss <= '0;
                cnt_pop <= '0;
            end else begin
                if (l0_push) cnt_in <= cnt_in + 1'b1;
                if (state == S_LDW_ISSUE || of_push) cnt_iss <= cnt_iss + 1'b1;
                if (of_pop) cnt_pop <= cnt_pop + 1'b1;
            end
            if (l0_push) l0_wp <= (l0_wp == l0_aw'(l0_depth-1)) ? '0 : l0_wp + 1'b1;
            if (l0_pop)  l0_rp <= (l0_rp == l0_aw'(l0_depth-1)) ? '0 : l0_rp + 1'b1;
            if (l0_push && !l0_pop)      l0_cnt <= l0_cnt + 1'b1;
            else if (!l0_push && l0_pop) l0_cnt <= l0_cnt - 1'b1;
            if (of_push) of_wp <= of_wp + 1'b1;
            if (of_pop)  of_rp <= of_rp + 1'b1;
            if (of_push && !of_pop)      of_cnt <= of_cnt + 1'b1;
            else if (!of_push && of_pop) of_cnt <= of_cnt - 1'b1;
            for (int c = 0; c < col; c++) begin
                if (state == S_LDW_ISSUE && l0_pop && cnt_iss == cnt_bw'(c))
                    w_vec[c] <= l0_head;
                if (state == S_RD_ACC && out_ready)
                    acc[c] <= '0;
                else if (of_pop && acc_q)
                    acc[c] <= acc[c] + of_head[psum_bw*c +: psum_bw];
            end
        end
    end
endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - randomized self-checking bench for corelet_seq against a matrix-arithmetic model
module tb_corelet_seq;
    localparam int ROW = 8;
    localparam int COL = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [7:0]   cmd_len = 8'd0;
    logic         cmd_acc = 1'b0;
    logic         cmd_relu = 1'b0;
    logic [31:0]  in_data = 32'd0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cmd_ready, in_ready, out_valid, busy, done;
    logic [127:0] out_data;

    int total = 0, bad = 0, timeouts = 0, stall_err = 0, fed_cnt = 0, snap = 0;
    int done_cnt = 0, ov_cnt = 0;
    int w_model [COL][ROW];
    int accm [COL];
    logic [31:0]  act_q [$];
    logic [127:0] got_q [$];
    logic [127:0] exp_q [$];

    corelet_seq dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_acc(cmd_acc), .cmd_relu(cmd_relu),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid) ov_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [127:0] model_out(input logic [31:0] a);
        logic [127:0] res;
        int s;
        res = '0;
        for (int c = 0; c < COL; c++) begin
            s = 0;
            for (int r = 0; r < ROW; r++) s += int'(a[4*r +: 4]) * w_model[c][r];
            res[16*c +: 16] = s[15:0];
        end
        return res;
    endfunction

    function automatic logic [127:0] model_acc(input logic relu);
        logic [127:0] res;
        logic [15:0] v;
        res = '0;
        for (int c = 0; c < COL; c++) begin
            v = accm[c][15:0];
            res[16*c +: 16] = (relu && v[15]) ? 16'd0 : v;
        end
        return res;
    endfunction

    function automatic logic [31:0] splat(input int a);
        logic [31:0] v;
        for (int r = 0; r < ROW; r++) v[4*r +: 4] = 4'(a);
        return v;
    endfunction

    task automatic model_accumulate();
        logic [127:0] e;
        foreach (act_q[i]) begin
            e = model_out(act_q[i]);
            for (int c = 0; c < COL; c++) accm[c] = (accm[c] + int'(e[16*c +: 16])) & 32'hFFFF;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input int len, input logic acc, input logic relu);
        int g = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 8'(len); cmd_acc = acc; cmd_relu = relu;
        #1;
        while (!cmd_ready && g < 200) begin
            @(negedge clk); #1; g++;
        end
        if (!cmd_ready) timeouts++;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'b00;
    endtask

    task automatic feed(input int n);
        int guard = 0;
        fed_cnt = 0;
        while (fed_cnt < n && guard < 3000) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = act_q[fed_cnt];
            #1;
            if (in_ready) fed_cnt++;
            guard++;
        end
        if (fed_cnt < n) timeouts++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int mode);
        int cyc = 0;
        logic stalled = 1'b0;
        logic [127:0] prev = '0;
        got_q.delete();
        while (got_q.size() < n && cyc < 3000) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 60);
            endcase
            if (mode == 3 && cyc == 60) snap = fed_cnt;
            #1;
            if (stalled && (!out_valid || out_data !== prev)) stall_err++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            stalled = out_valid && !out_ready;
            prev = out_data;
            cyc++;
        end
        if (got_q.size() < n) timeouts++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk); #1;
        while (busy && g < 3000) begin
            @(negedge clk); #1; g++;
        end
        if (busy) timeouts++;
    endtask

    task automatic load_weights();
        logic [31:0] v;
        act_q.delete();
        for (int k = 0; k < COL; k++) begin
            for (int r = 0; r < ROW; r++) v[4*r +: 4] = 4'(w_model[k][r]);
            act_q.push_back(v);
        end
        send_cmd(2'b01, 0, 1'b0, 1'b0);
        feed(COL);
        wait_idle();
    endtask

    task automatic set_weights(input int w);
        for (int c = 0; c < COL; c++)
            for (int r = 0; r < ROW; r++) w_model[c][r] = w;
    endtask

    task automatic run_exec(input int n, input logic acc, input int mode);
        exp_q.delete();
        foreach (act_q[i]) exp_q.push_back(model_out(act_q[i]));
        if (acc) model_accumulate();
        send_cmd(2'b10, n, acc, 1'b0);
        fork
            feed(n);
            begin
                if (!acc) collect(n, mode);
            end
        join
        wait_idle();
    endtask

    task automatic read_acc(input logic relu);
        send_cmd(2'b11, 0, 1'b0, relu);
        collect(1, 2);
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 128'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        for (int c = 0; c < COL; c++) accm[c] = 0;
        set_weights(0);
    endtask

    task automatic test_exec_basic();
        int d0;
        timeouts = 0;
        set_weights(1);
        d0 = done_cnt;
        load_weights();
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL loadw_done got=%0d exp=1", done_cnt - d0); end
        act_q.delete();
        repeat (4) act_q.push_back(splat(2));
        d0 = done_cnt;
        run_exec(4, 1'b0, 0);
        total++; if (got_q.size() !== 4) begin bad++; $display("FAIL exec_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++; if (got_q[i] !== {8{16'd16}}) begin bad++; $display("FAIL exec_vec%0d got=%h exp=%h", i, got_q[i], {8{16'd16}}); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL exec_done got=%0d exp=1", done_cnt - d0); end
        total++; if (timeouts !== 0) begin bad++; $display("FAIL exec_timeout got=%0d exp=0", timeouts); end
    endtask

    task automatic test_backpressure();
        timeouts = 0; stall_err = 0;
        act_q.delete();
        for (int i = 0; i < 4; i++) act_q.push_back($urandom);
        run_exec(4, 1'b0, 1);
        total++; if (got_q.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_vec%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        act_q.delete();
        for (int i = 0; i < 20; i++) act_q.push_back($urandom);
        run_exec(20, 1'b0, 3);
        total++; if (snap >= 20) begin bad++; $display("FAIL bp_in_ready_drop accepted=%0d exp<20", snap); end
        total++; if (got_q.size() !== 20) begin bad++; $display("FAIL bp_long_count got=%0d exp=20", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 20; i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_long_vec%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
        total++; if (timeouts !== 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=0", timeouts); end
    endtask

    task automatic test_accumulate();
        int o0;
        logic [127:0] r;
        timeouts = 0;
        act_q.delete();
        for (int a = 1; a <= 3; a++) act_q.push_back(splat(a));
        o0 = ov_cnt;
        run_exec(3, 1'b1, 0);
        total++; if (ov_cnt !== o0) begin bad++; $display("FAIL acc_out_valid got=%0d exp=0", ov_cnt - o0); end
        read_acc(1'b0);
        r = (got_q.size() > 0) ? got_q[0] : 'x;
        total++; if (r !== {8{16'd48}} || r !== model_acc(1'b0)) begin bad++; $display("FAIL acc_read got=%h exp=%h", r, {8{16'd48}}); end
        for (int c = 0; c < COL; c++) accm[c] = 0;
        read_acc(1'b0);
        r = (got_q.size() > 0) ? got_q[0] : 'x;
        total++; if (r !== 128'd0) begin bad++; $display("FAIL acc_cleared got=%h exp=0", r); end
        total++; if (timeouts !== 0) begin bad++; $display("FAIL acc_timeout got=%0d exp=0", timeouts); end
    endtask

    task automatic test_relu();
        logic [127:0] r;
        timeouts = 0;
        set_weights(-1);
        load_weights();
        act_q.delete();
        act_q.push_back(splat(1));
        run_exec(1, 1'b1, 0);
        read_acc(1'b0);
        r = (got_q.size() > 0) ? got_q[0] : 'x;
        total++; if (r !== {8{16'hFFF8}}) begin bad++; $display("FAIL relu_off got=%h exp=%h", r, {8{16'hFFF8}}); end
        for (int c = 0; c < COL; c++) accm[c] = 0;
        run_exec(1, 1'b1, 0);
        read_acc(1'b1);
        r = (got_q.size() > 0) ? got_q[0] : 'x;
        total++; if (r !== 128'd0 || r !== model_acc(1'b1)) begin bad++; $display("FAIL relu_on got=%h exp=0", r); end
        for (int c = 0; c < COL; c++) accm[c] = 0;
        total++; if (timeouts !== 0) begin bad++; $display("FAIL relu_timeout got=%0d exp=0", timeouts); end
    endtask

    task automatic test_nop_zero();
        logic [1:0] ops [2];
        ops[0] = 2'b00; ops[1] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = $urandom;
            send_cmd(ops[k], 0, 1'b0, 1'b0);
            #1;
            total++; if (done !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL zero_done op%0d done=%b in_ready=%b exp=1,0", k, done, in_ready); end
            @(negedge clk); #1;
            total++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_idle op%0d done=%b cmd_ready=%b exp=0,1", k, done, cmd_ready); end
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [127:0] r;
        timeouts = 0;
        act_q.delete();
        for (int i = 0; i < 10; i++) act_q.push_back($urandom);
        send_cmd(2'b10, 10, 1'b1, 1'b0);
        feed(3);
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_idle busy=%b cmd_ready=%b exp=0,1", busy, cmd_ready); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=%0d", done_cnt, d0); end
        for (int c = 0; c < COL; c++) accm[c] = 0;
        set_weights(0);
        read_acc(1'b0);
        r = (got_q.size() > 0) ? got_q[0] : 'x;
        total++; if (r !== 128'd0) begin bad++; $display("FAIL midreset_acc got=%h exp=0", r); end
        total++; if (timeouts !== 0) begin bad++; $display("FAIL midreset_timeout got=%0d exp=0", timeouts); end
    endtask

    task automatic test_random();
        int n, w;
        logic acc, relu;
        logic [127:0] r, e;
        timeouts = 0; stall_err = 0;
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < COL; c++)
                for (int r2 = 0; r2 < ROW; r2++) begin
                    w = int'($urandom_range(0, 15));
                    w_model[c][r2] = (w > 7) ? w - 16 : w;
                end
            load_weights();
            n = int'($urandom_range(1, 12));
            acc = 1'($urandom_range(0, 1));
            act_q.delete();
            for (int i = 0; i < n; i++) act_q.push_back($urandom);
            run_exec(n, acc, 2);
            if (!acc) begin
                total++; if (got_q.size() !== n) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_q.size(), n); end
                for (int i = 0; i < got_q.size() && i < n; i++) begin
                    total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_vec%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
                end
            end
            if (acc || it == 5) begin
                relu = 1'($urandom_range(0, 1));
                e = model_acc(relu);
                read_acc(relu);
                r = (got_q.size() > 0) ? got_q[0] : 'x;
                total++; if (r !== e) begin bad++; $display("FAIL rnd%0d_acc got=%h exp=%h", it, r, e); end
                for (int c = 0; c < COL; c++) accm[c] = 0;
            end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL rnd_stable got=%0d exp=0", stall_err); end
        total++; if (timeouts !== 0) begin bad++; $display("FAIL rnd_timeout got=%0d exp=0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_exec_basic();
        test_backpressure();
        test_accumulate();
        test_relu();
        test_nop_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
